// File: rtl/eth_rx_frame_reader.sv
// ---------------------------------------------------------------------------
// eth_rx_frame_reader
//
// Consumer stage on the clk_i side of the Rx length/data async FIFO pair.
// Each frame is handled in four steps:
//   1. Pop one length word from the length FIFO.
//   2. Validate the length.
//   3. Pop exactly that many bytes from the data FIFO.
//   4. Either deliver the bytes as a valid/ready stream with sof/eof markers,
//      or flush them silently when the length is illegal.
// Frame and drop statistics are kept alongside.
//
// Optional feature macro: ETH_RX_STRIP_FCS_EN
//   When defined, the trailing 4 FCS bytes of each frame are popped but not
//   delivered. frame_len then reports the payload length, and frames of
//   4 bytes or fewer are dropped.
//
// Ports
//   clk_i, reset_n        clock, asynchronous active-low reset
//   rx_len_fifo_*         fall-through length FIFO (data, empty, read pulse)
//   rx_data_fifo_*        fall-through byte FIFO (data, empty, read)
//   out_data/valid/ready  registered byte stream towards the parser
//   out_sof/out_eof       first / last delivered byte markers
//   frame_len             length of the frame being delivered
//   frame_drop            one-cycle pulse after a dropped frame is flushed
//   frame_cnt             delivered frames (wrapping)
//   drop_cnt              dropped frames (saturating)
// ---------------------------------------------------------------------------
module eth_rx_frame_reader #(
    parameter int MAX_FRAME_LEN = 1518,
    parameter int MIN_FRAME_LEN = 1
) (
    input  logic        clk_i,
    input  logic        reset_n,
    input  logic [15:0] rx_len_fifo_data,
    input  logic        rx_len_fifo_empty,
    output logic        rx_len_fifo_read,
    input  logic [7:0]  rx_data_fifo_data,
    input  logic        rx_data_fifo_empty,
    output logic        rx_data_fifo_read,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic [15:0] frame_len,
    output logic        frame_drop,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);

`ifdef ETH_RX_STRIP_FCS_EN
    localparam logic FCS_STRIP = 1'b1;
`else
    localparam logic FCS_STRIP = 1'b0;
`endif

    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);
    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        STREAM,
        DROP
    } state_t;

    state_t      state_q,      state_d;
    logic [15:0] len_q,        len_d;
    logic [15:0] remain_q,     remain_d;
    logic        first_q,      first_d;
    logic [7:0]  out_data_q,   out_data_d;
    logic        out_valid_q,  out_valid_d;
    logic        out_sof_q,    out_sof_d;
    logic        out_eof_q,    out_eof_d;
    logic [15:0] frame_len_q,  frame_len_d;
    logic        frame_drop_q, frame_drop_d;
    logic [15:0] frame_cnt_q,  frame_cnt_d;
    logic [15:0] drop_cnt_q,   drop_cnt_d;

    logic out_free;
    logic keep_byte;
    logic last_kept;

    // The output register can take a new byte when it is empty or being accepted.
    assign out_free = !out_valid_q || out_ready;

    // With FCS stripping, the final four bytes (remain 4..1) are never kept.
    // The last delivered byte is then the one popped with remain == 5.
    assign keep_byte = !FCS_STRIP || (remain_q > 16'd4);
    assign last_kept = FCS_STRIP ? (remain_q == 16'd5) : (remain_q == 16'd1);

    // Next-state, FIFO pops and output-register loads.
    always_comb begin
        state_d           = state_q;
        len_d             = len_q;
        remain_d          = remain_q;
        first_d           = first_q;
        out_data_d        = out_data_q;
        out_sof_d         = out_sof_q;
        out_eof_d         = out_eof_q;
        out_valid_d       = out_valid_q && !out_ready;
        frame_len_d       = frame_len_q;
        frame_drop_d      = 1'b0;
        frame_cnt_d       = frame_cnt_q;
        drop_cnt_d        = drop_cnt_q;
        rx_len_fifo_read  = 1'b0;
        rx_data_fifo_read = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_len_fifo_empty && out_free) begin
                    rx_len_fifo_read = 1'b1;
                    len_d            = rx_len_fifo_data;
                    state_d          = CHECK;
                end
            end

            CHECK: begin
                remain_d = len_q;
                first_d  = 1'b1;
                if ((len_q < MIN_LEN) || (len_q > MAX_LEN) ||
                    (FCS_STRIP && (len_q <= 16'd4))) begin
                    state_d = DROP;
                end else begin
                    state_d     = STREAM;
                    frame_len_d = FCS_STRIP ? (len_q - 16'd4) : len_q;
                end
            end

            STREAM: begin
                if (!rx_data_fifo_empty && out_free) begin
                    rx_data_fifo_read = 1'b1;
                    remain_d          = remain_q - 16'd1;
                    if (keep_byte) begin
                        out_data_d  = rx_data_fifo_data;
                        out_sof_d   = first_q;
                        out_eof_d   = last_kept;
                        out_valid_d = 1'b1;
                        first_d     = 1'b0;
                    end
                    if (remain_q == 16'd1) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = IDLE;
                    end
                end
            end

            DROP: begin
                // A zero-length frame owns no data bytes, so it is retired without popping.
                if (remain_q == 16'd0) begin
                    frame_drop_d = 1'b1;
                    if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                    state_d = IDLE;
                end else if (!rx_data_fifo_empty) begin
                    rx_data_fifo_read = 1'b1;
                    remain_d          = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        frame_drop_d = 1'b1;
                        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers. An asynchronous reset aborts any frame in flight.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            len_q        <= 16'd0;
            remain_q     <= 16'd0;
            first_q      <= 1'b0;
            out_data_q   <= 8'd0;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            frame_len_q  <= 16'd0;
            frame_drop_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
            drop_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            remain_q     <= remain_d;
            first_q      <= first_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            frame_len_q  <= frame_len_d;
            frame_drop_q <= frame_drop_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign out_eof    = out_eof_q;
    assign frame_len  = frame_len_q;
    assign frame_drop = frame_drop_q;
    assign frame_cnt  = frame_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_frame_reader
//
// Bench for eth_rx_frame_reader. The length and data FIFOs are modelled with
// queues. Expected beats go into a scoreboard queue as frames are queued, and
// are popped as the DUT delivers them. Honours ETH_RX_STRIP_FCS_EN.
// ---------------------------------------------------------------------------
module tb_eth_rx_frame_reader;

    logic        clk_i = 1'b0;
    logic        reset_n;
    logic [15:0] rx_len_fifo_data;
    logic        rx_len_fifo_empty;
    logic        rx_len_fifo_read;
    logic [7:0]  rx_data_fifo_data;
    logic        rx_data_fifo_empty;
    logic        rx_data_fifo_read;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sof;
    logic        out_eof;
    logic [15:0] frame_len;
    logic        frame_drop;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } beat_t;

    typedef struct {
        int         len;
        int         mode;
        logic [7:0] base;
        int         expBeats;
    } vec_t;

    beat_t       expQ[$];
    logic [15:0] lenQ[$];
    logic [7:0]  dataQ[$];

    int errors = 0;
    int checks = 0;
    int pops = 0;
    int beats = 0;
    int dropPulses = 0;
    int readyMode = 0;
    int expPops = 0;
    int expFrames = 0;
    int expDrops = 0;
    int expFrameLen = 0;

    eth_rx_frame_reader dut (
        .clk_i              (clk_i),
        .reset_n            (reset_n),
        .rx_len_fifo_data   (rx_len_fifo_data),
        .rx_len_fifo_empty  (rx_len_fifo_empty),
        .rx_len_fifo_read   (rx_len_fifo_read),
        .rx_data_fifo_data  (rx_data_fifo_data),
        .rx_data_fifo_empty (rx_data_fifo_empty),
        .rx_data_fifo_read  (rx_data_fifo_read),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_sof            (out_sof),
        .out_eof            (out_eof),
        .frame_len          (frame_len),
        .frame_drop         (frame_drop),
        .frame_cnt          (frame_cnt),
        .drop_cnt           (drop_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // FIFO heads are presented on the falling edge so they are stable at the rising edge.
    always @(negedge clk_i) begin
        if (!reset_n || dataQ.size() == 0) begin
            rx_data_fifo_empty = 1'b1;
            rx_data_fifo_data  = 8'd0;
        end else begin
            rx_data_fifo_empty = 1'b0;
            rx_data_fifo_data  = dataQ[0];
        end
        if (!reset_n || lenQ.size() == 0) begin
            rx_len_fifo_empty = 1'b1;
            rx_len_fifo_data  = 16'd0;
        end else begin
            rx_len_fifo_empty = 1'b0;
            rx_len_fifo_data  = lenQ[0];
        end
    end

    // FIFO pops happen on the rising edge where the DUT asserts read.
    always @(posedge clk_i) begin
        logic [7:0]  dummyByte;
        logic [15:0] dummyLen;
        if (reset_n) begin
            if (rx_data_fifo_read) begin
                checkOutput("data_read_while_empty", int'(rx_data_fifo_empty), 0);
                if (dataQ.size() > 0) begin
                    dummyByte = dataQ.pop_front();
                    pops++;
                end
            end
            if (rx_len_fifo_read) begin
                checkOutput("len_read_while_empty", int'(rx_len_fifo_empty), 0);
                if (lenQ.size() > 0) dummyLen = lenQ.pop_front();
            end
        end
    end

    // Downstream ready pattern: 0 = always ready, 1 = toggling, other = random.
    always @(posedge clk_i) begin
        #1;
        case (readyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: scoreboard compare on accept, hold check while stalled.
    always @(negedge clk_i) begin
        beat_t e;
        beat_t cur;
        logic  prevStall;
        beat_t prevBeat;
        cur = '{data: out_data, sof: out_sof, eof: out_eof};
        if (!reset_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_hold_valid", int'(out_valid), 1);
                checkOutput("stall_hold_beat", int'(cur), int'(prevBeat));
            end
            if (out_valid && out_ready) begin
                beats++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got data %0d with no beat expected", out_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("beat_data", int'(out_data), int'(e.data));
                    checkOutput("beat_sof", int'(out_sof), int'(e.sof));
                    checkOutput("beat_eof", int'(out_eof), int'(e.eof));
                end
            end
            prevStall = out_valid && !out_ready;
            prevBeat  = cur;
            if (frame_drop) dropPulses++;
        end
    end

    task automatic pushBytes(input logic [7:0] base, input int from, input int upto);
        for (int i = from; i < upto; i++) dataQ.push_back(8'(int'(base) + i));
    endtask

    // Queue one frame: length word, the first nowBytes data bytes, and the
    // scoreboard entries the frame should produce.
    task automatic applyStimulus(input int len, input logic [7:0] base, input int nowBytes);
        int    dl;
        bit    drop;
        beat_t b;
        drop = (len < 1) || (len > 1518);
`ifdef ETH_RX_STRIP_FCS_EN
        drop = drop || (len <= 4);
        dl   = len - 4;
`else
        dl   = len;
`endif
        lenQ.push_back(16'(len));
        pushBytes(base, 0, nowBytes);
        expPops += len;
        if (drop) begin
            expDrops++;
        end else begin
            for (int i = 0; i < dl; i++) begin
                b.data = 8'(int'(base) + i);
                b.sof  = (i == 0);
                b.eof  = (i == dl - 1);
                expQ.push_back(b);
            end
            expFrames   = (expFrames + 1) & 16'hFFFF;
            expFrameLen = dl;
        end
    endtask

    task automatic waitDone(input string name, input int budget);
        int n;
        n = 0;
        while ((lenQ.size() != 0 || dataQ.size() != 0 || expQ.size() != 0 || out_valid)
               && n < budget) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: still busy after %0d cycles", name, n);
        end
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    task automatic checkFrame(input string name);
        checkOutput({name, "_frame_cnt"}, int'(frame_cnt), expFrames);
        checkOutput({name, "_drop_cnt"}, int'(drop_cnt), expDrops);
        checkOutput({name, "_frame_len"}, int'(frame_len), expFrameLen);
        checkOutput({name, "_pops"}, pops, expPops);
        checkOutput({name, "_drop_pulses"}, dropPulses, expDrops);
    endtask

    vec_t vecs[11];

    initial begin
        int beatsBefore;
        int popsBefore;
        int n;

`ifdef ETH_RX_STRIP_FCS_EN
        vecs[0]  = '{len: 3,    mode: 0, base: 8'hA1, expBeats: 0};
        vecs[1]  = '{len: 3,    mode: 1, base: 8'hA1, expBeats: 0};
        vecs[2]  = '{len: 1600, mode: 0, base: 8'h10, expBeats: 0};
        vecs[3]  = '{len: 2,    mode: 0, base: 8'h20, expBeats: 0};
        vecs[4]  = '{len: 1518, mode: 2, base: 8'h30, expBeats: 1514};
        vecs[5]  = '{len: 1519, mode: 0, base: 8'h40, expBeats: 0};
        vecs[6]  = '{len: 1,    mode: 1, base: 8'h50, expBeats: 0};
        vecs[7]  = '{len: 0,    mode: 0, base: 8'h00, expBeats: 0};
        vecs[8]  = '{len: 8,    mode: 0, base: 8'h00, expBeats: 4};
        vecs[9]  = '{len: 4,    mode: 0, base: 8'h70, expBeats: 0};
        vecs[10] = '{len: 5,    mode: 2, base: 8'h60, expBeats: 1};
`else
        vecs[0]  = '{len: 3,    mode: 0, base: 8'hA1, expBeats: 3};
        vecs[1]  = '{len: 3,    mode: 1, base: 8'hA1, expBeats: 3};
        vecs[2]  = '{len: 1600, mode: 0, base: 8'h10, expBeats: 0};
        vecs[3]  = '{len: 2,    mode: 0, base: 8'h20, expBeats: 2};
        vecs[4]  = '{len: 1518, mode: 2, base: 8'h30, expBeats: 1518};
        vecs[5]  = '{len: 1519, mode: 0, base: 8'h40, expBeats: 0};
        vecs[6]  = '{len: 1,    mode: 1, base: 8'h50, expBeats: 1};
        vecs[7]  = '{len: 0,    mode: 0, base: 8'h00, expBeats: 0};
        vecs[8]  = '{len: 8,    mode: 0, base: 8'h00, expBeats: 8};
        vecs[9]  = '{len: 4,    mode: 0, base: 8'h70, expBeats: 4};
        vecs[10] = '{len: 5,    mode: 2, base: 8'h60, expBeats: 5};
`endif

        // Reset state
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_data", int'(out_data), 0);
        checkOutput("reset_frame_len", int'(frame_len), 0);
        checkOutput("reset_frame_cnt", int'(frame_cnt), 0);
        checkOutput("reset_drop_cnt", int'(drop_cnt), 0);
        checkOutput("reset_frame_drop", int'(frame_drop), 0);
        repeat (2) @(posedge clk_i);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // Table-driven frames
        for (int i = 0; i < 11; i++) begin
            readyMode   = vecs[i].mode;
            beatsBefore = beats;
            applyStimulus(vecs[i].len, vecs[i].base, vecs[i].len);
            waitDone($sformatf("vec%0d", i), vecs[i].len * 6 + 60);
            checkOutput($sformatf("vec%0d_beats", i), beats - beatsBefore, vecs[i].expBeats);
            checkFrame($sformatf("vec%0d", i));
        end

        // Data FIFO runs dry after byte 2 of a 4-byte frame
        readyMode   = 0;
        beatsBefore = beats;
        popsBefore  = pops;
        applyStimulus(4, 8'hB0, 2);
        repeat (12) @(posedge clk_i);
        #1;
        checkOutput("starve_pops", pops - popsBefore, 2);
`ifdef ETH_RX_STRIP_FCS_EN
        checkOutput("starve_beats", beats - beatsBefore, 0);
`else
        checkOutput("starve_beats", beats - beatsBefore, 2);
`endif
        pushBytes(8'hB0, 2, 4);
        waitDone("starve", 100);
        checkFrame("starve");

        // Asynchronous reset in the middle of a delivered frame
        readyMode = 0;
        applyStimulus(20, 8'hC0, 20);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        checkOutput("midreset_started", int'(out_valid), 1);
        repeat (3) @(posedge clk_i);
        #1 reset_n = 1'b0;
        lenQ.delete();
        dataQ.delete();
        expQ.delete();
        #1;
        checkOutput("midreset_out_valid", int'(out_valid), 0);
        checkOutput("midreset_out_data", int'(out_data), 0);
        checkOutput("midreset_out_sof", int'(out_sof), 0);
        checkOutput("midreset_out_eof", int'(out_eof), 0);
        checkOutput("midreset_frame_len", int'(frame_len), 0);
        checkOutput("midreset_frame_cnt", int'(frame_cnt), 0);
        checkOutput("midreset_data_read", int'(rx_data_fifo_read), 0);
        expFrames   = 0;
        expDrops    = 0;
        expFrameLen = 0;
        dropPulses  = 0;
        expPops     = pops;
        repeat (3) @(posedge clk_i);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        beatsBefore = beats;
        applyStimulus(6, 8'hD0, 6);
        waitDone("postreset", 100);
`ifdef ETH_RX_STRIP_FCS_EN
        checkOutput("postreset_beats", beats - beatsBefore, 2);
`else
        checkOutput("postreset_beats", beats - beatsBefore, 6);
`endif
        checkFrame("postreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
